// File: rtl/register_array.sv
// CPU register file: two combinational read ports, one synchronous write port.
// Define REG_ZERO_HARDWIRED_EN to make register 0 a constant zero.
module register_array #(
  parameter int register_num   = 32,
  parameter int register_width = 32,
  localparam int AW = (register_num > 1) ? $clog2(register_num) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AW-1:0]             reg1_address,
  input  logic [AW-1:0]             reg2_address,
  input  logic [AW-1:0]             write_reg_address,
  input  logic                      write_enable,
  input  logic [register_width-1:0] write_data,
  output logic [register_width-1:0] reg1,
  output logic [register_width-1:0] reg2
);

`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit ZERO_HARDWIRED = 1'b1;
`else
  localparam bit ZERO_HARDWIRED = 1'b0;
`endif

  localparam logic [AW:0] NUM = (AW+1)'(register_num);

  logic [register_width-1:0] regs [register_num];

  genvar gi;
  generate
    for (gi = 0; gi < register_num; gi++) begin : g_reg
      if (ZERO_HARDWIRED && gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_store
        logic [register_width-1:0] value_reg;
        // An X write_enable takes the else path, so the register holds.
        always_ff @(posedge clk) begin
          if (rst) begin
            value_reg <= '0;
          end else if (write_enable && write_reg_address == AW'(gi)) begin
            value_reg <= write_data;
          end
        end
        assign regs[gi] = value_reg;
      end
    end
  endgenerate

  // Addresses beyond the last register (non power-of-2 sizes) read as zero.
  always_comb begin
    reg1 = '0;
    reg2 = '0;
    if ({1'b0, reg1_address} < NUM) reg1 = regs[reg1_address];
    if ({1'b0, reg2_address} < NUM) reg2 = regs[reg2_address];
  end

endmodule

// File: tb/tb_register_array.sv
// Self-checking bench for register_array: directed steps plus a random phase
// checked against an array-based model of the register file.
module tb_register_array;
  localparam int N  = 32;
  localparam int W  = 32;
  localparam int AW = 5;

`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit ZERO_HW = 1'b1;
`else
  localparam bit ZERO_HW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] reg1_address = '0;
  logic [AW-1:0] reg2_address = '0;
  logic [AW-1:0] write_reg_address = '0;
  logic          write_enable = 1'b0;
  logic [W-1:0]  write_data = '0;
  logic [W-1:0]  reg1;
  logic [W-1:0]  reg2;

  logic [W-1:0] model [N];
  int checks = 0;
  int errors = 0;

  register_array #(.register_num(N), .register_width(W)) dut (
    .clk(clk), .rst(rst),
    .reg1_address(reg1_address), .reg2_address(reg2_address),
    .write_reg_address(write_reg_address), .write_enable(write_enable),
    .write_data(write_data), .reg1(reg1), .reg2(reg2)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] expect_reg(input int a);
    if (ZERO_HW && a == 0) return '0;
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, updating the model with what the edge should do.
  task automatic step();
    if (rst) begin
      for (int i = 0; i < N; i++) model[i] = '0;
    end else if (write_enable === 1'b1) begin
      model[write_reg_address] = write_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int a, input logic [W-1:0] d);
    write_enable = 1'b1;
    write_reg_address = AW'(a);
    write_data = d;
    step();
    $display("write r%0d <= %h", a, d);
  endtask

  task automatic read_pair(input string tag, input int a, input int b,
                           input logic [W-1:0] ea, input logic [W-1:0] eb);
    reg1_address = AW'(a);
    reg2_address = AW'(b);
    #1;
    $display("read %s: r%0d=%h r%0d=%h", tag, a, reg1, b, reg2);
    check({tag, "_port1"}, reg1, ea);
    check({tag, "_port2"}, reg2, eb);
  endtask

  initial begin
    int addrs [4] = '{0, 5, 9, 31};
    for (int i = 0; i < N; i++) model[i] = 'x;

    // Reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    foreach (addrs[i]) read_pair("reset", addrs[i], addrs[i], 32'h0, 32'h0);

    // Sequential writes, including a negative value
    write(0, 32'd10);
    write(1, 32'd20);
    write(2, 32'd30);
    write(5, 32'd50);
    write(9, -32'sd10);
    write_enable = 1'b0;
    read_pair("r0_r5", 0, 5, ZERO_HW ? 32'h0 : 32'd10, 32'd50);
    read_pair("r1_r2", 1, 2, 32'd20, 32'd30);
    read_pair("r9_r9", 9, 9, 32'hFFFF_FFF6, 32'hFFFF_FFF6);

    // Disabled writes leave r1 untouched
    write_enable = 1'b0;
    write_reg_address = 5'd1;
    write_data = 32'd99;
    repeat (3) step();
    read_pair("we_low", 1, 1, 32'd20, 32'd20);

    // X write enable also changes nothing
    write_enable = 1'bx;
    step();
    write_enable = 1'b0;
    read_pair("we_x", 1, 2, 32'd20, 32'd30);

    // Read-during-write: old value before the edge, new value after
    reg1_address = 5'd3;
    write_enable = 1'b1;
    write_reg_address = 5'd3;
    write_data = 32'd7;
    #1;
    check("rdw_before", reg1, 32'h0);
    step();
    write_enable = 1'b0;
    #1;
    check("rdw_after", reg1, 32'd7);

    // Combinational read without a clock edge
    @(negedge clk);
    reg1_address = 5'd5;
    #1;
    check("comb_r5", reg1, 32'd50);
    reg1_address = 5'd9;
    #1;
    check("comb_r9", reg1, 32'hFFFF_FFF6);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      int ra;
      int rb;
      ra = $urandom_range(N - 1);
      rb = $urandom_range(N - 1);
      reg1_address = AW'(ra);
      reg2_address = AW'(rb);
      write_enable = ($urandom_range(3) != 0);
      write_reg_address = AW'($urandom_range(N - 1));
      write_data = $urandom;
      #1;
      $display("rand %0d: we=%0b wa=%0d wd=%h r%0d=%h r%0d=%h", n, write_enable,
               write_reg_address, write_data, ra, reg1, rb, reg2);
      if (model[ra] !== 'x || (ZERO_HW && ra == 0)) check("rand_port1", reg1, expect_reg(ra));
      if (model[rb] !== 'x || (ZERO_HW && rb == 0)) check("rand_port2", reg2, expect_reg(rb));
      step();
    end
    write_enable = 1'b0;

    // Fill r4 and r9, then reset with a pending write
    write(4, 32'h1234_5678);
    write(9, 32'hDEAD_BEEF);
    read_pair("pre_rst", 4, 9, 32'h1234_5678, 32'hDEAD_BEEF);
    rst = 1'b1;
    write_enable = 1'b1;
    write_reg_address = 5'd4;
    write_data = 32'd5;
    step();
    rst = 1'b0;
    write_enable = 1'b0;
    read_pair("mid_rst", 4, 9, 32'h0, 32'h0);
    for (int i = 0; i < N; i += 2) read_pair("rst_all", i, i + 1, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
